// File: rtl/servo_pkg.sv
// Shared state encoding and default timing for the servo PWM decoder.
package servo_pkg;

  localparam int unsigned DEF_TICK_DIV   = 100;
  localparam int unsigned DEF_WIDTH_MIN  = 500;
  localparam int unsigned DEF_WIDTH_MAX  = 2500;
  localparam int unsigned DEF_PERIOD_MAX = 25000;
  localparam int unsigned DEF_CW         = 15;
  localparam int unsigned PW_W           = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for pwm_in plus edge detection against the previous synced sample.
module pwm_edge_sync (
  input  logic Clck_in,
  input  logic reset_Clock,
  input  logic pwm_in,
  output logic level,
  output logic rise_c,
  output logic fall_c,
  output logic settled
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] fill;

  // fill marks when s2 holds a real sample rather than its reset value
  always_ff @(posedge Clck_in) begin
    if (reset_Clock) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      fill <= 2'b00;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      prev <= s2;
      fill <= {fill[0], 1'b1};
    end
  end

  always_comb begin
    level   = s2;
    rise_c  = s2 & ~prev;
    fall_c  = ~s2 & prev;
    settled = fill[1];
  end

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures pwm_in high time in 1 us ticks, strobes valid widths,
// flags out-of-range pulses and loss of signal.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned WIDTH_MIN  = DEF_WIDTH_MIN,
  parameter int unsigned WIDTH_MAX  = DEF_WIDTH_MAX,
  parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic            Clck_in,
  input  logic            reset_Clock,
  input  logic            pwm_in,
  output logic [PW_W-1:0] pulse_width_us,
  output logic            sample_stb,
  output logic            width_err,
  output logic            signal_lost
);

  localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic            level;
  logic            rise;
  logic            fall;
  logic            settled;
  state_t          state;
  state_t          state_nxt;
  logic [PSW-1:0]  presc;
  logic [PSW-1:0]  presc_nxt;
  logic [CW-1:0]   hi_cnt;
  logic [CW-1:0]   hi_nxt;
  logic [CW-1:0]   hi_inc;
  logic [CW-1:0]   per_cnt;
  logic [CW-1:0]   per_nxt;
  logic [CW-1:0]   per_inc;
  logic [PW_W-1:0] width_nxt;
  logic            stb_nxt;
  logic            err_nxt;
  logic            lost_nxt;
  logic            tick;
  logic            per_lim;
  logic            in_range;

  pwm_edge_sync u_sync (
    .Clck_in     (Clck_in),
    .reset_Clock (reset_Clock),
    .pwm_in      (pwm_in),
    .level       (level),
    .rise_c      (rise),
    .fall_c      (fall),
    .settled     (settled)
  );

  // Tick and saturating counter increments; the fall cycle's tick belongs to the pulse
  always_comb begin
    tick     = (presc == PSW'(TICK_DIV - 1));
    per_lim  = (per_cnt == CW'(PERIOD_MAX));
    hi_inc   = (tick && (hi_cnt != CW'(PERIOD_MAX))) ? hi_cnt + CW'(1) : hi_cnt;
    per_inc  = (tick && !per_lim) ? per_cnt + CW'(1) : per_cnt;
    in_range = (hi_inc >= CW'(WIDTH_MIN)) && (hi_inc <= CW'(WIDTH_MAX));
  end

  always_ff @(posedge Clck_in) begin
    if (reset_Clock) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (settled && !level) state_nxt = ARMED;
      ARMED:   if (rise) state_nxt = HIGH;
      HIGH: begin
        if (per_lim)   state_nxt = IDLE;
        else if (fall) state_nxt = LOW;
      end
      LOW: begin
        if (rise)         state_nxt = HIGH;
        else if (per_lim) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    presc_nxt = tick ? '0 : presc + PSW'(1);
    hi_nxt    = hi_cnt;
    per_nxt   = per_cnt;
    width_nxt = pulse_width_us;
    stb_nxt   = 1'b0;
    err_nxt   = 1'b0;
    lost_nxt  = signal_lost;
    if (rise) presc_nxt = '0;
    unique case (state)
      ARMED: begin
        if (rise) begin
          hi_nxt  = '0;
          per_nxt = '0;
        end
      end
      HIGH: begin
        if (per_lim) begin
          lost_nxt = 1'b1;
        end else begin
          hi_nxt  = hi_inc;
          per_nxt = per_inc;
          if (fall) begin
            if (in_range) begin
              width_nxt = PW_W'(hi_inc);
              stb_nxt   = 1'b1;
              lost_nxt  = 1'b0;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
      end
      LOW: begin
        if (rise) begin
          hi_nxt  = '0;
          per_nxt = '0;
        end else if (per_lim) begin
          lost_nxt = 1'b1;
        end else begin
          per_nxt = per_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clck_in) begin
    if (reset_Clock) begin
      presc          <= '0;
      hi_cnt         <= '0;
      per_cnt        <= '0;
      pulse_width_us <= '0;
      sample_stb     <= 1'b0;
      width_err      <= 1'b0;
      signal_lost    <= 1'b1;
    end else begin
      presc          <= presc_nxt;
      hi_cnt         <= hi_nxt;
      per_cnt        <= per_nxt;
      pulse_width_us <= width_nxt;
      sample_stb     <= stb_nxt;
      width_err      <= err_nxt;
      signal_lost    <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
`timescale 1ns/1ps
// Bench for servo_pwm_decoder; timing parameters are scaled down so pulse trains stay short.
module tb_servo_pwm_decoder;

  localparam int TD   = 3;
  localparam int WMIN = 20;
  localparam int WMAX = 100;
  localparam int PMAX = 400;
  localparam int CWB  = 10;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        pwm_in = 1'b0;
  logic [11:0] pulse_width_us;
  logic        sample_stb;
  logic        width_err;
  logic        signal_lost;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int n_both  = 0;
  int stb_cyc[$];
  int stb_w[$];
  int err_cyc[$];

  servo_pwm_decoder #(
    .TICK_DIV   (TD),
    .WIDTH_MIN  (WMIN),
    .WIDTH_MAX  (WMAX),
    .PERIOD_MAX (PMAX),
    .CW         (CWB)
  ) dut (
    .Clck_in        (clk),
    .reset_Clock    (rst),
    .pwm_in         (pwm_in),
    .pulse_width_us (pulse_width_us),
    .sample_stb     (sample_stb),
    .width_err      (width_err),
    .signal_lost    (signal_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: cyc at the negedge equals the index of the edge that produced the value
  always @(negedge clk) begin
    if (sample_stb === 1'b1) begin
      stb_cyc.push_back(cyc);
      stb_w.push_back(int'(pulse_width_us));
    end
    if (width_err === 1'b1) err_cyc.push_back(cyc);
    if (sample_stb === 1'b1 && width_err === 1'b1) n_both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: width is whole microseconds of high time; accepted if inside the inclusive window
  function automatic int model_width(input int h_cycles);
    return h_cycles / TD;
  endfunction

  function automatic bit model_ok(input int w);
    return (w >= WMIN) && (w <= WMAX);
  endfunction

  task automatic clear_events();
    stb_cyc.delete();
    stb_w.delete();
    err_cyc.delete();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic hold_low(input int n);
    pwm_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // High for h cycles, low for l cycles; fe is the edge that first samples the low level
  task automatic drive_pulse(input int h, input int l, output int fe);
    pwm_in = 1'b1;
    repeat (h) @(posedge clk);
    #1 pwm_in = 1'b0;
    fe = cyc + 1;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pwm_in = 1'b0;
    apply_reset(3);
    clear_events();
    n_tests++; if (pulse_width_us !== 12'd0) begin n_fail++; $display("FAIL reset width: got %0d want 0", pulse_width_us); end
    n_tests++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL reset stb: got %b want 0", sample_stb); end
    n_tests++; if (width_err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", width_err); end
    n_tests++; if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL reset lost: got %b want 1", signal_lost); end
    hold_low(20);
    n_tests++; if (signal_lost !== 1'b1 || pulse_width_us !== 12'd0) begin n_fail++; $display("FAIL reset idle: lost=%b width=%0d want 1/0", signal_lost, pulse_width_us); end
    n_tests++; if (stb_cyc.size() != 0 || err_cyc.size() != 0) begin n_fail++; $display("FAIL reset events: stb=%0d err=%0d want 0/0", stb_cyc.size(), err_cyc.size()); end
  endtask

  task automatic test_nominal();
    int fe;
    apply_reset(2);
    hold_low(20);
    n_tests++; if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL nominal lost before first: got %b want 1", signal_lost); end
    for (int i = 0; i < 3; i++) begin
      clear_events();
      drive_pulse(60 * TD, 300 * TD, fe);
      n_tests++;
      if (stb_cyc.size() != 1 || err_cyc.size() != 0) begin
        n_fail++; $display("FAIL nominal[%0d] events: stb=%0d err=%0d want 1/0", i, stb_cyc.size(), err_cyc.size());
      end else begin
        n_tests++; if (stb_cyc[0] != fe + 2) begin n_fail++; $display("FAIL nominal[%0d] latency: got edge %0d want %0d", i, stb_cyc[0], fe + 2); end
        n_tests++; if (stb_w[0] != 60) begin n_fail++; $display("FAIL nominal[%0d] stb width: got %0d want 60", i, stb_w[0]); end
      end
      n_tests++; if (pulse_width_us !== 12'd60) begin n_fail++; $display("FAIL nominal[%0d] width: got %0d want 60", i, pulse_width_us); end
      n_tests++; if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL nominal[%0d] lost: got %b want 0", i, signal_lost); end
    end
  endtask

  task automatic test_boundaries();
    int hs[6] = '{WMIN * TD, WMAX * TD, (WMIN - 1) * TD, WMIN * TD - 1, WMAX * TD + TD - 1, (WMAX + 1) * TD};
    int fe, w, exp_w;
    bit ok, exp_lost;
    apply_reset(2);
    hold_low(20);
    exp_w = 0;
    exp_lost = 1'b1;
    foreach (hs[i]) begin
      w  = model_width(hs[i]);
      ok = model_ok(w);
      if (ok) begin exp_w = w; exp_lost = 1'b0; end
      clear_events();
      drive_pulse(hs[i], 150 * TD, fe);
      n_tests++;
      if (stb_cyc.size() != (ok ? 1 : 0) || err_cyc.size() != (ok ? 0 : 1)) begin
        n_fail++; $display("FAIL bound[%0d] events: stb=%0d err=%0d want %0d/%0d", i, stb_cyc.size(), err_cyc.size(), ok, !ok);
      end else if (ok) begin
        n_tests++; if (stb_cyc[0] != fe + 2 || stb_w[0] != w) begin n_fail++; $display("FAIL bound[%0d] stb: edge %0d width %0d want %0d/%0d", i, stb_cyc[0], stb_w[0], fe + 2, w); end
      end else begin
        n_tests++; if (err_cyc[0] != fe + 2) begin n_fail++; $display("FAIL bound[%0d] err latency: got %0d want %0d", i, err_cyc[0], fe + 2); end
      end
      n_tests++; if (int'(pulse_width_us) != exp_w) begin n_fail++; $display("FAIL bound[%0d] width: got %0d want %0d", i, pulse_width_us, exp_w); end
      n_tests++; if (signal_lost !== exp_lost) begin n_fail++; $display("FAIL bound[%0d] lost: got %b want %b", i, signal_lost, exp_lost); end
    end
  endtask

  task automatic test_lost_low();
    int fe;
    apply_reset(2);
    hold_low(20);
    clear_events();
    drive_pulse(60 * TD, 100 * TD, fe);
    n_tests++; if (stb_cyc.size() != 1 || signal_lost !== 1'b0) begin n_fail++; $display("FAIL lostlow first: stb=%0d lost=%b want 1/0", stb_cyc.size(), signal_lost); end
    hold_low((PMAX - 5 - 160) * TD);
    n_tests++; if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL lostlow early: got %b want 0", signal_lost); end
    hold_low(10 * TD);
    n_tests++; if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL lostlow limit: got %b want 1", signal_lost); end
    hold_low(200 * TD);
    n_tests++; if (signal_lost !== 1'b1 || pulse_width_us !== 12'd60) begin n_fail++; $display("FAIL lostlow hold: lost=%b width=%0d want 1/60", signal_lost, pulse_width_us); end
    n_tests++; if (stb_cyc.size() != 1 || err_cyc.size() != 0) begin n_fail++; $display("FAIL lostlow events: stb=%0d err=%0d want 1/0", stb_cyc.size(), err_cyc.size()); end
    clear_events();
    drive_pulse(60 * TD, 100 * TD, fe);
    n_tests++;
    if (stb_cyc.size() != 1) begin
      n_fail++; $display("FAIL lostlow recover stb count: got %0d want 1", stb_cyc.size());
    end else begin
      n_tests++; if (stb_cyc[0] != fe + 2 || stb_w[0] != 60) begin n_fail++; $display("FAIL lostlow recover stb: edge %0d width %0d want %0d/60", stb_cyc[0], stb_w[0], fe + 2); end
    end
    n_tests++; if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL lostlow recover lost: got %b want 0", signal_lost); end
  endtask

  task automatic test_lost_high();
    int fe;
    apply_reset(2);
    hold_low(20);
    clear_events();
    drive_pulse(60 * TD, 200 * TD, fe);
    n_tests++; if (stb_cyc.size() != 1 || signal_lost !== 1'b0) begin n_fail++; $display("FAIL losthigh first: stb=%0d lost=%b want 1/0", stb_cyc.size(), signal_lost); end
    clear_events();
    pwm_in = 1'b1;
    repeat ((PMAX - 5) * TD) @(posedge clk);
    #1;
    n_tests++; if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL losthigh early: got %b want 0", signal_lost); end
    repeat (10 * TD) @(posedge clk);
    #1;
    n_tests++; if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL losthigh limit: got %b want 1", signal_lost); end
    repeat (100 * TD) @(posedge clk);
    hold_low(100 * TD);
    n_tests++; if (stb_cyc.size() != 0 || err_cyc.size() != 0) begin n_fail++; $display("FAIL losthigh release events: stb=%0d err=%0d want 0/0", stb_cyc.size(), err_cyc.size()); end
    n_tests++; if (signal_lost !== 1'b1 || pulse_width_us !== 12'd60) begin n_fail++; $display("FAIL losthigh release: lost=%b width=%0d want 1/60", signal_lost, pulse_width_us); end
    clear_events();
    drive_pulse(40 * TD, 200 * TD, fe);
    n_tests++;
    if (stb_cyc.size() != 1) begin
      n_fail++; $display("FAIL losthigh recover stb count: got %0d want 1", stb_cyc.size());
    end else begin
      n_tests++; if (stb_cyc[0] != fe + 2 || stb_w[0] != 40) begin n_fail++; $display("FAIL losthigh recover stb: edge %0d width %0d want %0d/40", stb_cyc[0], stb_w[0], fe + 2); end
    end
    n_tests++; if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL losthigh recover lost: got %b want 0", signal_lost); end
  endtask

  task automatic test_reset_high();
    int fe;
    pwm_in = 1'b1;
    apply_reset(4);
    clear_events();
    repeat (28 * TD) @(posedge clk);
    hold_low(200 * TD);
    n_tests++; if (stb_cyc.size() != 0 || err_cyc.size() != 0) begin n_fail++; $display("FAIL resethigh partial events: stb=%0d err=%0d want 0/0", stb_cyc.size(), err_cyc.size()); end
    n_tests++; if (signal_lost !== 1'b1 || pulse_width_us !== 12'd0) begin n_fail++; $display("FAIL resethigh outputs: lost=%b width=%0d want 1/0", signal_lost, pulse_width_us); end
    clear_events();
    drive_pulse(48 * TD, 200 * TD, fe);
    n_tests++;
    if (stb_cyc.size() != 1 || err_cyc.size() != 0) begin
      n_fail++; $display("FAIL resethigh next events: stb=%0d err=%0d want 1/0", stb_cyc.size(), err_cyc.size());
    end else begin
      n_tests++; if (stb_cyc[0] != fe + 2 || stb_w[0] != 48) begin n_fail++; $display("FAIL resethigh next stb: edge %0d width %0d want %0d/48", stb_cyc[0], stb_w[0], fe + 2); end
    end
  endtask

  task automatic test_reset_mid();
    int fe;
    apply_reset(2);
    hold_low(20);
    drive_pulse(60 * TD, 200 * TD, fe);
    clear_events();
    pwm_in = 1'b1;
    repeat (40 * TD) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (pulse_width_us !== 12'd0 || signal_lost !== 1'b1) begin n_fail++; $display("FAIL resetmid outputs: width=%0d lost=%b want 0/1", pulse_width_us, signal_lost); end
    n_tests++; if (sample_stb !== 1'b0 || width_err !== 1'b0) begin n_fail++; $display("FAIL resetmid strobes: stb=%b err=%b want 0/0", sample_stb, width_err); end
    repeat (40 * TD) @(posedge clk);
    hold_low(200 * TD);
    n_tests++; if (stb_cyc.size() != 0 || err_cyc.size() != 0) begin n_fail++; $display("FAIL resetmid events: stb=%0d err=%0d want 0/0", stb_cyc.size(), err_cyc.size()); end
    clear_events();
    drive_pulse(48 * TD, 200 * TD, fe);
    n_tests++;
    if (stb_cyc.size() != 1) begin
      n_fail++; $display("FAIL resetmid next stb count: got %0d want 1", stb_cyc.size());
    end else begin
      n_tests++; if (stb_cyc[0] != fe + 2 || stb_w[0] != 48) begin n_fail++; $display("FAIL resetmid next stb: edge %0d width %0d want %0d/48", stb_cyc[0], stb_w[0], fe + 2); end
    end
    n_tests++; if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL resetmid next lost: got %b want 0", signal_lost); end
  endtask

  task automatic test_random();
    int fe, h, l, w, exp_w;
    bit ok, exp_lost;
    apply_reset(2);
    hold_low(20);
    exp_w = 0;
    exp_lost = 1'b1;
    n_both = 0;
    for (int i = 0; i < 30; i++) begin
      h  = int'($urandom_range(110 * TD, 1));
      l  = int'($urandom_range(200 * TD, 4));
      w  = model_width(h);
      ok = model_ok(w);
      if (ok) begin exp_w = w; exp_lost = 1'b0; end
      clear_events();
      drive_pulse(h, l, fe);
      n_tests++;
      if (stb_cyc.size() != (ok ? 1 : 0) || err_cyc.size() != (ok ? 0 : 1)) begin
        n_fail++; $display("FAIL rand[%0d] events h=%0d: stb=%0d err=%0d want %0d/%0d", i, h, stb_cyc.size(), err_cyc.size(), ok, !ok);
      end else if (ok) begin
        n_tests++; if (stb_cyc[0] != fe + 2 || stb_w[0] != w) begin n_fail++; $display("FAIL rand[%0d] stb h=%0d: edge %0d width %0d want %0d/%0d", i, h, stb_cyc[0], stb_w[0], fe + 2, w); end
      end else begin
        n_tests++; if (err_cyc[0] != fe + 2) begin n_fail++; $display("FAIL rand[%0d] err latency h=%0d: got %0d want %0d", i, h, err_cyc[0], fe + 2); end
      end
      n_tests++; if (int'(pulse_width_us) != exp_w) begin n_fail++; $display("FAIL rand[%0d] width: got %0d want %0d", i, pulse_width_us, exp_w); end
      n_tests++; if (signal_lost !== exp_lost) begin n_fail++; $display("FAIL rand[%0d] lost: got %b want %b", i, signal_lost, exp_lost); end
    end
    n_tests++; if (n_both != 0) begin n_fail++; $display("FAIL rand exclusive: stb and err together %0d times want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_lost_low();
    test_lost_high();
    test_reset_high();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Measures the high time of an incoming servo-style PWM signal (e.g. an RC receiver channel) in 1 us units.
- Input path of the servo project: the inverse of the clock-divider/PWM-generation path. It turns a pulse train back into a number.
- Reports valid widths with a one-cycle strobe.
- Flags out-of-range pulses and loss of signal.

Parameters:
- TICK_DIV, 100: Clck_in cycles per 1 us tick (100 MHz board clock).
- WIDTH_MIN, 500: smallest accepted pulse width, us.
- WIDTH_MAX, 2500: largest accepted pulse width, us.
- PERIOD_MAX, 25000: rising-to-rising or stuck-high limit, us; exceeding it means signal lost.
- CW, 15: tick counter width; must satisfy 2^CW > PERIOD_MAX.

Ports:
- Clck_in, input, 1: system clock; the only clock.
- reset_Clock, input, 1: synchronous, active-high reset.
- pwm_in, input, 1: asynchronous PWM input.
- pulse_width_us, output, 12: last accepted width in us.
- sample_stb, output, 1: one-cycle pulse when pulse_width_us updates.
- width_err, output, 1: one-cycle pulse when a completed pulse is outside [WIDTH_MIN, WIDTH_MAX].
- signal_lost, output, 1: level; high while no valid signal is present.

Behaviour:
- Interface: one clock, Clck_in. reset_Clock is synchronous and active-high; it is sampled only on the rising edge of Clck_in.
- Reset values:
  - pulse_width_us = 0, sample_stb = 0, width_err = 0, signal_lost = 1.
  - FSM = IDLE; synchronizer and edge registers = 0; prescaler and counters = 0.
- Input conditioning: two-flop synchronizer, then a previous-value register.
  - rise = s2 & ~prev; fall = ~s2 & prev.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1, then wraps to 0.
  - Forced to 0 on every rise, so tick boundaries align to the pulse start.
- FSM states:
  - IDLE: wait for synced level 0, then go to ARMED. This prevents measuring a partial pulse after reset.
  - ARMED: on rise, clear hi_cnt and per_cnt, then go to HIGH.
  - HIGH:
    - hi_cnt and per_cnt increment on tick.
    - On fall: go to LOW and evaluate w = hi_cnt.
    - If per_cnt reaches PERIOD_MAX while still high: signal_lost <= 1, go to IDLE, no strobe.
  - LOW:
    - per_cnt increments on tick.
    - On rise: clear counters, go to HIGH.
    - If per_cnt reaches PERIOD_MAX: signal_lost <= 1, go to IDLE.
- Evaluation on fall:
  - If WIDTH_MIN <= w <= WIDTH_MAX: pulse_width_us <= w, sample_stb = 1 for one cycle, signal_lost <= 0.
  - Otherwise: width_err = 1 for one cycle; pulse_width_us and signal_lost are unchanged.
- Quantization: w = floor(high_cycles / TICK_DIV). Both comparison bounds are inclusive.
- Latency:
  - pwm_in must be sampled low at clock edge N.
  - sample_stb / width_err are high in the cycle following edge N+2, i.e. fixed 3-cycle latency.
- Saturation: counters never wrap; they stop at PERIOD_MAX.
- sample_stb and width_err are mutually exclusive and never held longer than one cycle.
- Simultaneous events:
  - rise and the per_cnt limit in the same cycle: rise wins (go to HIGH).
  - reset_Clock overrides everything in the cycle it is sampled.
- Reset mid-pulse: no strobe is produced, outputs return to reset values, and the FSM restarts in IDLE.
- Glitches: any synced high pulse shorter than WIDTH_MIN us produces width_err only. No filtering beyond the synchronizer.

Decomposition:
- Shared package servo_pkg contains:
  - FSM state encoding: IDLE, ARMED, HIGH, LOW (2 bits).
  - Default timing constants: TICK_DIV, WIDTH_MIN, WIDTH_MAX, PERIOD_MAX.
  - Width of pulse_width_us (12).
- One sub-module: pwm_edge_sync.
  - Contains the 2-flop synchronizer, prev register and the rise/fall/level outputs.
  - Same Clck_in and reset_Clock.
- Prescaler, counters and FSM stay in the top module.

Test Plan:
- Reset, then 1500 us high / 18500 us low for 3 periods -> sample_stb once per period; pulse_width_us = 1500; signal_lost falls to 0 after the first strobe; stb exactly 3 cycles after each pwm_in fall.
- Boundary widths 500, 2500, 499, 2501 us -> strobes with 500 and 2500; width_err (no strobe) for 499 and 2501; pulse_width_us keeps 2500.
- Valid 1500 us pulse, then pwm_in held low 30 ms -> signal_lost = 1 once per_cnt reaches 25000 ticks; next valid pulse clears it with a strobe.
- pwm_in held high 30 ms after a valid pulse -> signal_lost = 1 and FSM in IDLE. On release low and a new 1000 us pulse -> strobe with 1000.
- pwm_in high when reset_Clock deasserts, falling 700 us later -> no strobe and no width_err for that pulse; next full 1200 us pulse -> strobe with 1200.
- reset_Clock asserted for 1 cycle in the middle of a 2000 us pulse -> no strobe for that pulse; outputs at reset values; following pulse measured normally.
